voice_osc_mixer: RTL and testbench



---
 rtl/voice_osc_mixer_if.sv | 22 ++
 rtl/voice_osc_mixer.sv | 73 +++++++
 tb/tb_voice_osc_mixer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/voice_osc_mixer_if.sv
// Period words in from the tone lookup, per-voice waves, mix and audio bit out.
// slave = the mixer, master = whatever drives the periods and watches the outputs.
interface voice_osc_mixer_if;
  logic [31:0] period0;
  logic [31:0] period1;
  logic [31:0] period2;
  logic [31:0] period3;
  logic [3:0]  wave;
  logic [3:0]  voice_active;
  logic [2:0]  mix;
  logic        pwm_out;

  modport master (
    output period0, period1, period2, period3,
    input  wave, voice_active, mix, pwm_out
  );

  modport slave (
    input  period0, period1, period2, period3,
    output wave, voice_active, mix, pwm_out
  );
endinterface

// File: rtl/voice_osc_mixer.sv
// Four square-wave voices from period words, summed into a 0..4 mix and
// rendered as a first-order sigma-delta bit stream for the audio pin.
module voice_osc_mixer #(
  parameter logic [31:0] CLOCK_SPEED = 32'd25_000_000
) (
  input logic              clk,
  input logic              reset,
  voice_osc_mixer_if.slave bus
);

  // CLOCK_SPEED only documents the clock shared with the tone lookup.
  if (CLOCK_SPEED == 32'd0) begin : g_no_clock_speed
  end

  logic [31:0] period   [4];
  logic [31:0] period_q [4];
  logic [31:0] cnt      [4];
  logic [3:0]  wave_q;
  logic [3:0]  active_q;
  logic [2:0]  mix_q;
  logic [1:0]  acc_q;
  logic        pwm_q;
  logic [2:0]  pop;
  logic [2:0]  sum;

  assign period[0] = bus.period0;
  assign period[1] = bus.period1;
  assign period[2] = bus.period2;
  assign period[3] = bus.period3;

  always_comb begin
    pop = {2'b00, wave_q[0]} + {2'b00, wave_q[1]}
        + {2'b00, wave_q[2]} + {2'b00, wave_q[3]};
    sum = {1'b0, acc_q} + mix_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i]      <= '0;
        period_q[i] <= '0;
      end
      wave_q   <= '0;
      active_q <= '0;
      mix_q    <= '0;
      acc_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        period_q[i] <= period[i];
        active_q[i] <= (period[i] != 32'd0);
        // A silent voice or any new period restarts the phase; restart beats wrap.
        if (period[i] == 32'd0 || period[i] != period_q[i]) begin
          cnt[i]    <= '0;
          wave_q[i] <= 1'b0;
        end else begin
          wave_q[i] <= (cnt[i] < (period[i] >> 1));
          cnt[i]    <= (cnt[i] >= period[i] - 32'd1) ? 32'd0 : cnt[i] + 32'd1;
        end
      end
      mix_q <= pop;
      // sum >= 4 emits a one and subtracts 4, which leaves exactly sum[1:0].
      pwm_q <= sum[2];
      acc_q <= sum[1:0];
    end
  end

  assign bus.wave         = wave_q;
  assign bus.voice_active = active_q;
  assign bus.mix          = mix_q;
  assign bus.pwm_out      = pwm_q;

endmodule

// File: tb/tb_voice_osc_mixer.sv
// Self-checking bench: directed tone scenarios plus random period changes,
// compared every cycle against a phase/cumulative-sum model of the mixer.
module tb_voice_osc_mixer;

  logic        clk;
  logic        reset;
  logic [31:0] tb_p [4];
  bit          check_en;
  int          n_cmp;
  int          n_bad;

  voice_osc_mixer_if bus ();

  assign bus.period0 = tb_p[0];
  assign bus.period1 = tb_p[1];
  assign bus.period2 = tb_p[2];
  assign bus.period3 = tb_p[3];

  voice_osc_mixer #(.CLOCK_SPEED(32'd25_000_000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: phase = edges since the voice last restarted; pwm from the
  // running total of mix values (a one each time the total crosses a multiple of 4).
  longint unsigned pq_m    [4];
  longint unsigned phase_m [4];
  logic [3:0]      wave_m;
  logic [3:0]      va_m;
  logic [2:0]      mix_m;
  logic            pwm_m;
  longint unsigned total_m;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    longint unsigned p;
    longint unsigned t_new;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        pq_m[i]    = 0;
        phase_m[i] = 0;
      end
      wave_m  = '0;
      va_m    = '0;
      mix_m   = '0;
      pwm_m   = 1'b0;
      total_m = 0;
    end else begin
      t_new   = total_m + mix_m;
      pwm_m   = ((t_new / 4) != (total_m / 4));
      total_m = t_new;
      mix_m   = 3'($countones(wave_m));
      for (int i = 0; i < 4; i++) begin
        p = tb_p[i];
        va_m[i] = (p != 0);
        if (p == 0 || p != pq_m[i]) begin
          phase_m[i] = 0;
          wave_m[i]  = 1'b0;
        end else begin
          phase_m[i] = phase_m[i] + 1;
          wave_m[i]  = (((phase_m[i] - 1) % p) < (p / 2));
        end
        pq_m[i] = p;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      cmp("wave", 32'(bus.wave), 32'(wave_m));
      cmp("voice_active", 32'(bus.voice_active), 32'(va_m));
      cmp("mix", 32'(bus.mix), 32'(mix_m));
      cmp("pwm_out", 32'(bus.pwm_out), 32'(pwm_m));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_p(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    tb_p[0] = a; tb_p[1] = b; tb_p[2] = c; tb_p[3] = d;
  endtask

  task automatic pwm_window(output int ones);
    ones = 0;
    repeat (4) begin
      tick(1);
      ones += int'(bus.pwm_out);
    end
  endtask

  initial begin
    int ones;
    int highs;
    int r;
    n_cmp    = 0;
    n_bad    = 0;
    check_en = 1'b0;
    reset    = 1'b1;
    set_p(32'd8, 32'd0, 32'd0, 32'd0);
    tick(1);
    check_en = 1'b1;
    cmp("rst_wave", 32'(bus.wave), 32'h0);
    cmp("rst_active", 32'(bus.voice_active), 32'h0);
    cmp("rst_mix", 32'(bus.mix), 32'h0);
    cmp("rst_pwm", 32'(bus.pwm_out), 32'h0);

    // period0 = 8: 4 high, 4 low
    reset = 1'b0;
    tick(1);
    cmp("p8_restart_wave", 32'(bus.wave), 32'h0);
    cmp("p8_active", 32'(bus.voice_active), 32'h1);
    tick(1);
    cmp("p8_first_high", 32'(bus.wave[0]), 32'h1);
    tick(3);
    cmp("p8_still_high", 32'(bus.wave[0]), 32'h1);
    tick(1);
    cmp("p8_low", 32'(bus.wave[0]), 32'h0);
    tick(4);
    cmp("p8_wrap_high", 32'(bus.wave[0]), 32'h1);
    tick(4);

    // 8 -> 6 mid-period: restart, then 3 high, 3 low
    set_p(32'd6, 32'd0, 32'd0, 32'd0);
    tick(1);
    cmp("p6_change_low", 32'(bus.wave[0]), 32'h0);
    tick(1);
    cmp("p6_high1", 32'(bus.wave[0]), 32'h1);
    tick(2);
    cmp("p6_high3", 32'(bus.wave[0]), 32'h1);
    tick(1);
    cmp("p6_low", 32'(bus.wave[0]), 32'h0);
    tick(20);

    // period1 = 5 over 10 periods: 20 high cycles of 50
    set_p(32'd6, 32'd5, 32'd0, 32'd0);
    tick(1);
    highs = 0;
    repeat (50) begin
      tick(1);
      highs += int'(bus.wave[1]);
    end
    cmp("p5_high_count", 32'(highs), 32'd20);

    // mix = 1 -> one pwm one per 4 cycles
    set_p(32'd1000, 32'd0, 32'd0, 32'd0);
    tick(21);
    cmp("mix1", 32'(bus.mix), 32'd1);
    pwm_window(ones);
    cmp("mix1_density", 32'(ones), 32'd1);

    // mix = 3 -> three ones per 4 cycles
    set_p(32'd900, 32'd900, 32'd900, 32'd0);
    tick(21);
    cmp("mix3", 32'(bus.mix), 32'd3);
    pwm_window(ones);
    cmp("mix3_density", 32'(ones), 32'd3);

    // all voices at period 2
    set_p(32'd2, 32'd2, 32'd2, 32'd2);
    tick(1);
    cmp("p2_restart", 32'(bus.wave), 32'h0);
    tick(1);
    cmp("p2_all_high", 32'(bus.wave), 32'hF);
    tick(1);
    cmp("p2_all_low", 32'(bus.wave), 32'h0);
    cmp("p2_mix4", 32'(bus.mix), 32'd4);
    tick(1);
    cmp("p2_mix0", 32'(bus.mix), 32'd0);
    tick(10);

    // reset mid-tone, then resume from phase 0
    set_p(32'd8, 32'd0, 32'd0, 32'd0);
    tick(11);
    reset = 1'b1;
    tick(1);
    cmp("midrst_wave", 32'(bus.wave), 32'h0);
    cmp("midrst_mix", 32'(bus.mix), 32'h0);
    cmp("midrst_pwm", 32'(bus.pwm_out), 32'h0);
    reset = 1'b0;
    tick(1);
    cmp("resume_restart", 32'(bus.wave), 32'h0);
    tick(1);
    cmp("resume_high", 32'(bus.wave[0]), 32'h1);
    tick(3);
    cmp("resume_high4", 32'(bus.wave[0]), 32'h1);
    tick(1);
    cmp("resume_low", 32'(bus.wave[0]), 32'h0);

    // period 0 and 1 never toggle
    set_p(32'd0, 32'd1, 32'd0, 32'd0);
    highs = 0;
    repeat (30) begin
      tick(1);
      highs += int'(bus.wave != 4'h0);
    end
    cmp("p0p1_no_toggle", 32'(highs), 32'd0);
    cmp("p0p1_active", 32'(bus.voice_active), 32'h2);

    // random period changes and occasional resets, model-checked every cycle
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 29) == 0) begin
        r = int'($urandom_range(0, 9));
        case (r)
          0: tb_p[$urandom_range(0, 3)] = 32'd0;
          1: tb_p[$urandom_range(0, 3)] = 32'd1;
          2: tb_p[$urandom_range(0, 3)] = 32'd2;
          3: tb_p[$urandom_range(0, 3)] = 32'($urandom_range(100, 300));
          default: tb_p[$urandom_range(0, 3)] = 32'($urandom_range(2, 40));
        endcase
      end
      reset = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
